// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX packet arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Header byte: fixed tag in the high nibble, source id in the low nibble.
  function automatic logic [7:0] build_header(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// master: producers + UART FIFO model; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ-1:0][7:0]  i_req_data;   // requester k at [8k+7:8k]
  logic [N_REQ-1:0]       i_req_last;
  logic [N_REQ-1:0]       o_req_ready;
  logic [N_REQ-1:0]       o_grant;
  logic                   i_tx_full;
  logic                   o_valid_tx;
  logic [7:0]             o_tx_sys_data;
  logic                   o_busy;
  logic                   o_timeout;
  logic [ID_W-1:0]        o_timeout_id;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_full,
    input  o_req_ready, o_grant, o_valid_tx, o_tx_sys_data,
           o_busy, o_timeout, o_timeout_id
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_full,
    output o_req_ready, o_grant, o_valid_tx, o_tx_sys_data,
           o_busy, o_timeout, o_timeout_id
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward
// from last_grant+1 with wrap-around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);

  int              pos;
  logic [ID_W-1:0] idx;

  // Scan the N_REQ positions after last_grant; first hit wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      pos = int'(last_grant) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = ID_W'(pos);
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the UART TX FIFO.
// One owner at a time; optional {tag,id} header; idle watchdog release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HEADER_EN   = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int              CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  last_q,  last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ID_W-1:0]  to_id_q, to_id_d;

  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  logic             own_vld, own_last;
  logic [7:0]       own_data;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req        (bus.i_req_valid),
    .last_grant (last_q),
    .gnt_oh     (pick_oh),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

  assign own_vld  = bus.i_req_valid[owner_q];
  assign own_last = bus.i_req_last[owner_q];
  assign own_data = bus.i_req_data[owner_q];

  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_timeout_id = to_id_q;

  // State, ownership and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      to_id_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      to_id_q <= to_id_d;
    end
  end

  // Next-state and datapath outputs; outputs are pass-through from the
  // current inputs so a byte moves in the same cycle it is offered.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_d            = last_q;
    grant_d           = grant_q;
    cnt_d             = cnt_q;
    to_id_d           = to_id_q;
    bus.o_req_ready   = '0;
    bus.o_valid_tx    = 1'b0;
    bus.o_tx_sys_data = '0;
    bus.o_timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          grant_d = pick_oh;
          cnt_d   = '0;
          state_d = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
        end
      end

      ST_HEADER: begin
        if (!bus.i_tx_full) begin
          bus.o_valid_tx    = 1'b1;
          bus.o_tx_sys_data = build_header(4'(owner_q));
          state_d           = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (cnt_q == TO_VAL) begin
          // Starved owner: abandon the packet and move on.
          bus.o_timeout = 1'b1;
          to_id_d       = owner_q;
          last_d        = owner_q;
          grant_d       = '0;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else begin
          bus.o_req_ready[owner_q] = !bus.i_tx_full;
          if (own_vld && !bus.i_tx_full) begin
            bus.o_valid_tx    = 1'b1;
            bus.o_tx_sys_data = own_data;
            cnt_d             = '0;
            if (own_last) begin
              last_d  = owner_q;
              grant_d = '0;
              state_d = ST_IDLE;
            end
          end else if (!bus.i_tx_full) begin
            // A full FIFO is not the owner's fault, so only count here.
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the
// main DUT, a write log captures every UART strobe for later comparison.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus_nh ();

  uart_tx_arbiter #(.N_REQ(N), .HEADER_EN(1), .TIMEOUT_CYC(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  uart_tx_arbiter #(.N_REQ(N), .HEADER_EN(0), .TIMEOUT_CYC(16)) u_dut_nh (
    .clk (clk),
    .rst (rst),
    .bus (bus_nh.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Producer queues: {last, data}
  logic [8:0]   mem [N][16];
  int           wp [N];
  int           rp [N];
  logic [N-1:0] en;
  logic         tx_full;

  logic [7:0] wlog [$];
  int         wcyc [$];
  int cyc = 0, to_cnt = 0, to_cyc = 0, bad = 0;

  function automatic logic [31:0] lg(input int i);
    if (i >= 0 && i < wlog.size()) return 32'(wlog[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lc(input int i);
    if (i >= 0 && i < wcyc.size()) return 32'(wcyc[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (en[k] && rp[k] < wp[k]) begin
        bus.i_req_valid[k] = 1'b1;
        bus.i_req_data[k]  = mem[k][rp[k]][7:0];
        bus.i_req_last[k]  = mem[k][rp[k]][8];
      end else begin
        bus.i_req_valid[k] = 1'b0;
        bus.i_req_data[k]  = 8'h00;
        bus.i_req_last[k]  = 1'b0;
      end
    end
    bus.i_tx_full = tx_full;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    mem[k][wp[k]] = {l, d};
    wp[k]++;
  endtask

  task automatic clr_q();
    for (int k = 0; k < N; k++) begin
      wp[k] = 0;
      rp[k] = 0;
    end
  endtask

  // One clock: sample at negedge, retire accepted bytes after posedge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    acc = bus.i_req_valid & bus.o_req_ready;
    if (bus.o_valid_tx) begin
      wlog.push_back(bus.o_tx_sys_data);
      wcyc.push_back(cyc);
    end
    if (bus.o_valid_tx && bus.i_tx_full) bad++;
    if (bus.o_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) rp[k]++;
    drive();
  endtask

  task automatic do_rst();
    rst     = 1'b1;
    tx_full = 1'b0;
    en      = '1;
    clr_q();
    drive();
    tick();
    tick();
    rst = 1'b0;
    wlog.delete();
    wcyc.delete();
    to_cnt = 0;
  endtask

  logic [7:0] exp2 [12];
  int cv, t55, nw, fw;
  logic [7:0] nd;
  logic acc_nh;

  initial begin
    tx_full = 1'b0;
    en      = '1;
    clr_q();
    bus_nh.i_req_valid = '0;
    bus_nh.i_req_data  = '0;
    bus_nh.i_req_last  = '0;
    bus_nh.i_tx_full   = 1'b0;

    // Reset state, with a request already pending
    push(0, 8'h11, 1'b0);
    drive();
    #1 rst = 1'b1;
    #2;
    chk("rst_grant",   32'(bus.o_grant), 0);
    chk("rst_busy",    32'(bus.o_busy), 0);
    chk("rst_ready",   32'(bus.o_req_ready), 0);
    chk("rst_valid",   32'(bus.o_valid_tx), 0);
    chk("rst_data",    32'(bus.o_tx_sys_data), 0);
    chk("rst_timeout", 32'(bus.o_timeout), 0);
    chk("rst_to_id",   32'(bus.o_timeout_id), 0);

    // T1: single 3-byte packet from req0
    do_rst();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    drive();
    tick();
    cv = cyc;
    chk("t1_idle_nowr", 32'(wlog.size()), 0);
    chk("t1_grant",     32'(bus.o_grant), 'h1);
    chk("t1_busy",      32'(bus.o_busy), 1);
    repeat (4) tick();
    chk("t1_nwr", 32'(wlog.size()), 4);
    chk("t1_wr0", lg(0), 'hA0);
    chk("t1_wr1", lg(1), 'h11);
    chk("t1_wr2", lg(2), 'h22);
    chk("t1_wr3", lg(3), 'h33);
    chk("t1_lat",    lc(0), 32'(cv + 1));
    chk("t1_contig", lc(3), 32'(cv + 4));
    chk("t1_grant_end", 32'(bus.o_grant), 0);
    chk("t1_busy_end",  32'(bus.o_busy), 0);

    // T2: round robin over four 1-byte packets, then re-request 0 and 2
    do_rst();
    for (int k = 0; k < N; k++) push(k, 8'(8'hB0 + k), 1'b1);
    drive();
    repeat (12) tick();
    push(0, 8'hC0, 1'b1);
    push(2, 8'hC2, 1'b1);
    drive();
    repeat (8) tick();
    exp2 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2,
             8'hA3, 8'hB3, 8'hA0, 8'hC0, 8'hA2, 8'hC2};
    chk("t2_nwr", 32'(wlog.size()), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_wr%0d", i), lg(i), 32'(exp2[i]));

    // T3: FIFO full stall; watchdog must hold while full
    do_rst();
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    drive();
    repeat (4) tick();
    chk("t3_pre_nwr", 32'(wlog.size()), 3);
    chk("t3_pre_22",  lg(2), 'h22);
    tx_full = 1'b1;
    drive();
    #1;
    chk("t3_full_ready", 32'(bus.o_req_ready), 0);
    chk("t3_full_valid", 32'(bus.o_valid_tx), 0);
    repeat (5) tick();
    chk("t3_full_nwr", 32'(wlog.size()), 3);
    en[0] = 1'b0;
    drive();
    repeat (20) tick();
    chk("t3_no_timeout", 32'(to_cnt), 0);
    chk("t3_still_own",  32'(bus.o_grant), 'h1);
    tx_full = 1'b0;
    en[0]   = 1'b1;
    drive();
    tick();
    chk("t3_33_data", lg(wlog.size() - 1), 'h33);
    chk("t3_33_cyc",  lc(wcyc.size() - 1), 32'(cyc));
    chk("t3_grant_end", 32'(bus.o_grant), 0);

    // T4: watchdog release of req1, pending req2 served next
    do_rst();
    push(1, 8'h55, 1'b0);
    push(2, 8'h66, 1'b1);
    drive();
    repeat (3) tick();
    t55 = cyc;
    chk("t4_hdr", lg(0), 'hA1);
    chk("t4_55",  lg(1), 'h55);
    for (int i = 0; i < 40 && to_cnt == 0; i++) tick();
    chk("t4_fired", 32'(to_cnt), 1);
    chk("t4_delay", 32'(to_cyc - t55), 17);
    chk("t4_to_id", 32'(bus.o_timeout_id), 1);
    chk("t4_idle",  32'(bus.o_busy), 0);
    repeat (3) tick();
    chk("t4_next_hdr", lg(2), 'hA2);
    chk("t4_next_66",  lg(3), 'h66);
    chk("t4_single_pulse", 32'(to_cnt), 1);

    // T5: reset mid-payload, then req0 beats req3
    do_rst();
    push(1, 8'h71, 1'b0); push(1, 8'h72, 1'b0); push(1, 8'h73, 1'b1);
    drive();
    repeat (3) tick();
    chk("t5_pre_nwr",  32'(wlog.size()), 2);
    chk("t5_pre_gnt",  32'(bus.o_grant), 'h2);
    rst = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(bus.o_grant), 0);
    chk("t5_rst_busy",  32'(bus.o_busy), 0);
    chk("t5_rst_ready", 32'(bus.o_req_ready), 0);
    chk("t5_rst_valid", 32'(bus.o_valid_tx), 0);
    chk("t5_rst_to_id", 32'(bus.o_timeout_id), 0);
    repeat (3) tick();
    chk("t5_rst_nwr", 32'(wlog.size()), 2);
    clr_q();
    push(0, 8'h81, 1'b1);
    push(3, 8'h84, 1'b1);
    drive();
    rst = 1'b0;
    tick();
    chk("t5_regrant", 32'(bus.o_grant), 'h1);
    repeat (2) tick();
    chk("t5_hdr", lg(2), 'hA0);
    chk("t5_81",  lg(3), 'h81);

    // T6: no-header build, req2 single byte
    bus_nh.i_req_data[2]  = 8'h7E;
    bus_nh.i_req_last[2]  = 1'b1;
    bus_nh.i_req_valid[2] = 1'b1;
    nw = 0; nd = 8'h00; fw = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc_nh = bus_nh.i_req_valid[2] & bus_nh.o_req_ready[2];
      if (bus_nh.o_valid_tx) begin
        nw++;
        nd = bus_nh.o_tx_sys_data;
        fw = i;
      end
      @(posedge clk);
      #1;
      if (acc_nh) bus_nh.i_req_valid[2] = 1'b0;
    end
    chk("t6_nwr",  32'(nw), 1);
    chk("t6_data", 32'(nd), 'h7E);
    chk("t6_lat",  32'(fw), 1);

    chk("no_write_while_full", 32'(bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
